// File: rtl/frame_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_reader_pkg : shared frame geometry defaults and FSM encodings   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package frame_reader_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int ADDR_WIDTH_DEF = 19;
  localparam int DATA_WIDTH_DEF = 8;

  // Encodings are shared with other frame_buffer users; keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Counter width that stays legal for a dimension of 1.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_reader_pixel_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_reader_pixel_skid_fifo : 2-entry first-word-fall-through FIFO   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module frame_reader_pixel_skid_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_reader : raster-order frame_buffer reader with valid/ready out  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol
);

  localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int X_W    = ctr_width(IMG_WIDTH);
  localparam int Y_W    = ctr_width(IMG_HEIGHT);
  localparam int FIFO_W = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [X_W-1:0]        X_LAST    = X_W'(IMG_WIDTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic                  inflight_q, inflight_d;
  logic                  tag_sof_q, tag_sof_d;
  logic                  tag_eol_q, tag_eol_d;

  logic [1:0]            fifo_count;
  logic [FIFO_W-1:0]     fifo_dout;
  logic [2:0]            credit;
  logic                  pop, issue, last_issue, drained;

  frame_reader_pixel_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({tag_sof_q, tag_eol_q, rd_data}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_dout[DATA_WIDTH-1:0];
  assign m_eol   = m_valid & fifo_dout[DATA_WIDTH];
  assign m_sof   = m_valid & fifo_dout[DATA_WIDTH+1];
  assign pop     = m_valid & m_ready;

  // Buffered plus in-flight pixels after this cycle's pop must leave room for one more.
  assign credit     = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_READ) && (credit < 3'd2);
  assign last_issue = issue && (rd_addr_q == LAST_ADDR);
  assign drained    = (state_q == ST_DRAIN) && !inflight_q && (fifo_count == 2'd1) && pop;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    inflight_d = issue;
    tag_sof_d  = tag_sof_q;
    tag_eol_d  = tag_eol_q;
    if (issue) begin
      tag_sof_d = (x_q == '0) && (y_q == '0);
      tag_eol_d = (x_q == X_LAST);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          rd_addr_d = '0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      ST_READ: begin
        // The final address is held so rd_addr never leaves the frame.
        if (last_issue) begin
          state_d = ST_DRAIN;
        end else if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d   = ST_IDLE;
          rd_addr_d = '0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      tag_sof_q  <= tag_sof_d;
      tag_eol_q  <= tag_eol_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = drained;
  assign rd_addr = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_reader : randomized self-checking bench for frame_reader     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_frame_reader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int P  = W * H;
  localparam int W2 = 1;
  localparam int H2 = 3;
  localparam int P2 = W2 * H2;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, m_valid, m_ready, m_sof, m_eol;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;
  logic          b_start, b_busy, b_done, b_valid, b_ready, b_sof, b_eol;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rdata, b_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW+1:0] got_px[$];
  int            got_cyc[$];
  int            done_cyc[$];
  logic [DW+1:0] got_b_px[$];
  int            got_b_cyc[$];
  int            done_b_cyc[$];
  int            stall_viol = 0;
  logic [AW-1:0] max_addr = '0;
  logic          stall_prev = 1'b0;
  logic [DW+2:0] stall_snap = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame_buffer models: mem[i] = i + 8'h10, one-cycle registered read
  always @(posedge clk) rd_data <= 8'(rd_addr + 16);
  always @(posedge clk) b_rdata <= 8'(b_addr + 16);

  frame_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
  );

  frame_reader #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_w1 (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_addr(b_addr), .rd_data(b_rdata), .m_valid(b_valid), .m_ready(b_ready),
    .m_data(b_data), .m_sof(b_sof), .m_eol(b_eol)
  );

  // Observation recorder: accepted pixels, done pulses, stall stability, address range
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        got_px.push_back({m_sof, m_eol, m_data});
        got_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (b_valid && b_ready) begin
        got_b_px.push_back({b_sof, b_eol, b_data});
        got_b_cyc.push_back(cyc);
      end
      if (b_done) done_b_cyc.push_back(cyc);
      if (stall_prev && ({m_valid, m_sof, m_eol, m_data} != stall_snap)) stall_viol++;
      if (rd_addr > max_addr) max_addr = rd_addr;
    end
    stall_prev = m_valid && !m_ready && !rst;
    stall_snap = {m_valid, m_sof, m_eol, m_data};
  end

  // Reference pixel i of a frame of width w: {sof, eol, data}
  function automatic logic [DW+1:0] exp_px(input int i, input int w);
    logic [DW-1:0] d;
    d = 8'(i + 16);
    return {(i == 0), ((i % w) == (w - 1)), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_px.delete();
    got_cyc.delete();
    done_cyc.delete();
    got_b_px.delete();
    got_b_cyc.delete();
    done_b_cyc.delete();
    stall_viol = 0;
    max_addr   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; b_start = 1'b0; b_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); end
    checks++; if ({m_sof, m_eol} !== 2'b00) begin errors++; $display("FAIL reset_tags got %b exp 00", {m_sof, m_eol}); end
    checks++; if ({b_valid, b_busy} !== 2'b00) begin errors++; $display("FAIL reset_w1 got %b exp 00", {b_valid, b_busy}); end
    tick(); rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_stream();
    int  s;
    int  d0;
    logic exp_busy;
    clear_obs(); m_ready = 1'b1;
    tick(); start = 1'b1; s = cyc;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin tick(); start = 1'b0; end
      @(negedge clk);
      exp_busy = (k >= 1) && (k <= 10);
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL stream_busy k=%0d got %b exp %b", k, busy, exp_busy); end
    end
    tick();
    checks++; if (got_px.size() != P) begin errors++; $display("FAIL stream_count got %0d exp %0d", got_px.size(), P); end
    for (int i = 0; i < got_px.size() && i < P; i++) begin
      checks++;
      if (got_px[i] !== exp_px(i, W) || got_cyc[i] != s + 3 + i) begin
        errors++;
        $display("FAIL stream_px i=%0d got %h@%0d exp %h@%0d", i, got_px[i], got_cyc[i] - s, exp_px(i, W), 3 + i);
      end
    end
    d0 = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
    checks++;
    if (done_cyc.size() != 1 || d0 != P + 2) begin
      errors++; $display("FAIL stream_done got n=%0d at %0d exp n=1 at %0d", done_cyc.size(), d0, P + 2);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int k;
    clear_obs(); seen = 1'b0; k = 0;
    tick(); start = 1'b1; m_ready = 1'b1;
    while (!seen && k < 80) begin
      @(negedge clk); seen = done;
      tick(); start = 1'b0; k++;
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
    end
    tick();
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got no done exp done within 80"); end
    checks++; if (got_px.size() != P) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_px.size(), P); end
    for (int i = 0; i < got_px.size() && i < P; i++) begin
      checks++;
      if (got_px[i] !== exp_px(i, W)) begin errors++; $display("FAIL bp_px i=%0d got %h exp %h", i, got_px[i], exp_px(i, W)); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_viol); end
    checks++; if (max_addr > AW'(P - 1)) begin errors++; $display("FAIL bp_addr got max %0d exp <= %0d", max_addr, P - 1); end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cyc.size()); end
  endtask

  task automatic test_stall();
    bit seen;
    clear_obs(); seen = 1'b0;
    tick(); start = 1'b1; m_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin tick(); start = 1'b0; end
    @(negedge clk);
    checks++; if (rd_addr !== AW'(2)) begin errors++; $display("FAIL stall_addr got %0d exp 2", rd_addr); end
    checks++;
    if ({m_valid, m_sof, m_data} !== {2'b11, 8'h10}) begin
      errors++; $display("FAIL stall_head got v%b s%b %h exp v1 s1 10", m_valid, m_sof, m_data);
    end
    checks++; if (got_px.size() != 0) begin errors++; $display("FAIL stall_leak got %0d exp 0", got_px.size()); end
    for (int k = 0; k < 40 && !seen; k++) begin
      tick(); m_ready = 1'b1;
      @(negedge clk); seen = done;
    end
    tick();
    checks++; if (!seen) begin errors++; $display("FAIL stall_timeout got no done exp done within 40"); end
    checks++; if (got_px.size() != P) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_px.size(), P); end
    for (int i = 0; i < got_px.size() && i < P; i++) begin
      checks++;
      if (got_px[i] !== exp_px(i, W)) begin errors++; $display("FAIL stall_px i=%0d got %h exp %h", i, got_px[i], exp_px(i, W)); end
    end
  endtask

  task automatic test_ignored_start();
    int s;
    int d0;
    clear_obs(); m_ready = 1'b1;
    tick(); start = 1'b1; s = cyc;
    for (int k = 1; k < 16; k++) begin
      tick();
      start = (k == 4) || (k == 9) || (k == 10);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_restart got busy %b exp 0", busy); end
    tick(); start = 1'b0;
    checks++; if (got_px.size() != P) begin errors++; $display("FAIL ign_count got %0d exp %0d", got_px.size(), P); end
    for (int i = 0; i < got_px.size() && i < P; i++) begin
      checks++;
      if (got_px[i] !== exp_px(i, W)) begin errors++; $display("FAIL ign_px i=%0d got %h exp %h", i, got_px[i], exp_px(i, W)); end
    end
    d0 = (done_cyc.size() > 0) ? done_cyc[0] - s : -1;
    checks++;
    if (done_cyc.size() != 1 || d0 != P + 2) begin
      errors++; $display("FAIL ign_done got n=%0d at %0d exp n=1 at %0d", done_cyc.size(), d0, P + 2);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs(); m_ready = 1'b1;
    tick(); start = 1'b1;
    for (int k = 1; k <= 8; k++) begin tick(); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, m_data} !== {1'b1, 8'h15}) begin errors++; $display("FAIL rstmid_px got v%b %h exp v1 15", m_valid, m_data); end
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid, busy, done} !== 3'b000 || rd_addr !== '0) begin
      errors++; $display("FAIL rstmid_clear got v%b b%b d%b a%0d exp 0 0 0 0", m_valid, busy, done, rd_addr);
    end
    repeat (6) tick();
    checks++;
    if (done_cyc.size() != 0 || got_px.size() != 5) begin
      errors++; $display("FAIL rstmid_abort got done %0d px %0d exp done 0 px 5", done_cyc.size(), got_px.size());
    end
    clear_obs();
    tick(); start = 1'b1;
    for (int k = 1; k < 14; k++) begin tick(); start = 1'b0; end
    checks++; if (got_px.size() != P) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", got_px.size(), P); end
    for (int i = 0; i < got_px.size() && i < P; i++) begin
      checks++;
      if (got_px[i] !== exp_px(i, W)) begin errors++; $display("FAIL rstmid_px i=%0d got %h exp %h", i, got_px[i], exp_px(i, W)); end
    end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL rstmid_done got %0d exp 1", done_cyc.size()); end
  endtask

  task automatic test_width1();
    int s;
    int d0;
    clear_obs(); b_ready = 1'b1;
    tick(); b_start = 1'b1; s = cyc;
    for (int k = 1; k < 10; k++) begin tick(); b_start = 1'b0; end
    checks++; if (got_b_px.size() != P2) begin errors++; $display("FAIL w1_count got %0d exp %0d", got_b_px.size(), P2); end
    for (int i = 0; i < got_b_px.size() && i < P2; i++) begin
      checks++;
      if (got_b_px[i] !== exp_px(i, W2) || got_b_cyc[i] != s + 3 + i) begin
        errors++;
        $display("FAIL w1_px i=%0d got %h@%0d exp %h@%0d", i, got_b_px[i], got_b_cyc[i] - s, exp_px(i, W2), 3 + i);
      end
    end
    d0 = (done_b_cyc.size() > 0) ? done_b_cyc[0] - s : -1;
    checks++;
    if (done_b_cyc.size() != 1 || d0 != P2 + 2) begin
      errors++; $display("FAIL w1_done got n=%0d at %0d exp n=1 at %0d", done_b_cyc.size(), d0, P2 + 2);
    end
  endtask

  task automatic test_random();
    bit seen;
    int k;
    int last;
    for (int f = 0; f < 4; f++) begin
      clear_obs(); seen = 1'b0; k = 0;
      tick(); start = 1'b1; m_ready = ($urandom_range(0, 2) != 0);
      while (!seen && k < 200) begin
        @(negedge clk); seen = done;
        tick(); k++;
        start   = seen ? 1'b0 : ($urandom_range(0, 5) == 0);
        m_ready = ($urandom_range(0, 2) != 0);
      end
      start = 1'b0;
      repeat (2) tick();
      checks++; if (!seen) begin errors++; $display("FAIL rnd_timeout f=%0d got no done exp done within 200", f); end
      checks++; if (got_px.size() != P) begin errors++; $display("FAIL rnd_count f=%0d got %0d exp %0d", f, got_px.size(), P); end
      for (int i = 0; i < got_px.size() && i < P; i++) begin
        checks++;
        if (got_px[i] !== exp_px(i, W)) begin errors++; $display("FAIL rnd_px f=%0d i=%0d got %h exp %h", f, i, got_px[i], exp_px(i, W)); end
      end
      last = (got_cyc.size() > 0) ? got_cyc[got_cyc.size() - 1] : -1;
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != last) begin
        errors++; $display("FAIL rnd_done f=%0d got n=%0d exp n=1 at last accept %0d", f, done_cyc.size(), last);
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd_stable f=%0d got %0d changes exp 0", f, stall_viol); end
      checks++; if (max_addr > AW'(P - 1)) begin errors++; $display("FAIL rnd_addr f=%0d got max %0d exp <= %0d", f, max_addr, P - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_ignored_start();
    test_reset_mid();
    test_width1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
